// File: rtl/sum_seg_display.sv
// sum_seg_display: converts the 8-bit press count to BCD with an iterative
// double-dabble FSM and scans it onto a three-digit, common-anode,
// multiplexed seven-segment display with leading-zero blanking.
module sum_seg_display #(
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sum_in,
    output logic [7:0]  seg,
    output logic [2:0]  sel,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        cap;
    logic [19:0]       shreg;
    logic [19:0]       adj;
    logic [2:0]        step;
    logic [DIV_W-1:0]  div;
    logic [1:0]        idx;
    logic [3:0]        digit;
    logic              blank;
    logic [7:0]        seg_next;
    logic [2:0]        sel_next;

    // Segment pattern (active-low, dp off) for one decimal digit.
    function automatic logic [7:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 8'hC0;
            4'd1:    encode = 8'hF9;
            4'd2:    encode = 8'hA4;
            4'd3:    encode = 8'hB0;
            4'd4:    encode = 8'h99;
            4'd5:    encode = 8'h92;
            4'd6:    encode = 8'h82;
            4'd7:    encode = 8'hF8;
            4'd8:    encode = 8'h80;
            4'd9:    encode = 8'h90;
            default: encode = 8'hFF;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        adj = shreg;
        if (shreg[11:8] >= 4'd5)  adj[11:8]  = shreg[11:8]  + 4'd3;
        if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
        if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
    end

    // Conversion FSM: capture a changed count, run eight shift steps, publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cap   <= 8'd0;
            shreg <= 20'd0;
            step  <= 3'd0;
            bcd   <= 12'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sum_in != cap) begin
                        cap   <= sum_in;
                        shreg <= {12'd0, sum_in};
                        step  <= 3'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= adj << 1;
                    step  <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bcd   <= shreg[19:8];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan timebase: each digit slot lasts SCAN_DIV clocks, index rotates 0-1-2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            idx <= 2'd0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Pick the digit for the current slot and decide whether it is a leading zero.
    always_comb begin
        digit    = bcd[3:0];
        blank    = 1'b0;
        sel_next = 3'b110;
        case (idx)
            2'd1: begin
                digit    = bcd[7:4];
                blank    = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                sel_next = 3'b101;
            end
            2'd2: begin
                digit    = bcd[11:8];
                blank    = (bcd[11:8] == 4'd0);
                sel_next = 3'b011;
            end
            default: begin
                digit    = bcd[3:0];
                blank    = 1'b0;
                sel_next = 3'b110;
            end
        endcase
        seg_next = blank ? 8'hFF : encode(digit);
    end

    // Output register so seg and sel always switch together on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            sel <= 3'b111;
        end else begin
            seg <= seg_next;
            sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_sum_seg_display.sv
// tb_sum_seg_display: randomized and directed checks of sum_seg_display
// against a decimal-arithmetic reference model of the display.
module tb_sum_seg_display;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sum_in;
    logic [7:0]  seg;
    logic [2:0]  sel;
    logic [11:0] bcd;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int shown    = 0;

    logic [7:0] seg_lut [0:9];

    sum_seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sum_in (sum_in),
        .seg    (seg),
        .sel    (sel),
        .bcd    (bcd),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits of v packed as {hundreds, tens, units}.
    function automatic logic [11:0] exp_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Expected segment pattern for a given select pattern and displayed value.
    function automatic logic [7:0] exp_seg(input int v, input logic [2:0] s);
        case (s)
            3'b110:  return seg_lut[v % 10];
            3'b101:  return (v < 10)  ? 8'hFF : seg_lut[(v / 10) % 10];
            3'b011:  return (v < 100) ? 8'hFF : seg_lut[v / 100];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [2:0] next_sel(input logic [2:0] s);
        case (s)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Watch the scan for n cycles: pattern per slot, rotation order, slot length.
    task automatic check_scan(input int v, input int n);
        logic [2:0] prev;
        int run;
        bit full;
        prev = sel;
        run  = 0;
        full = 0;
        for (int i = 0; i < n; i++) begin
            checkOutput("scan_seg", {24'd0, seg}, {24'd0, exp_seg(v, sel)});
            checkOutput("scan_busy", {31'd0, busy}, 32'd0);
            if (sel != prev) begin
                checkOutput("scan_order", {29'd0, sel}, {29'd0, next_sel(prev)});
                if (full) checkOutput("scan_hold", run, SCAN_DIV);
                full = 1;
                run  = 1;
                prev = sel;
            end else begin
                run++;
            end
            wait_cycle();
        end
    endtask

    // Present a new count, wait for its conversion (bounded) and check bcd.
    task automatic applyStimulus(input int v, input string tag);
        int n;
        sum_in = 8'(v);
        if (v == shown) begin
            repeat (2) wait_cycle();
            checkOutput("same_busy", {31'd0, busy}, 32'd0);
            checkOutput(tag, {20'd0, bcd}, {20'd0, exp_bcd(v)});
            return;
        end
        n = 0;
        do begin
            wait_cycle();
            n++;
        end while (!busy && n < 4);
        if (!busy) begin
            checkOutput("busy_rise_timeout", 32'd0, 32'd1);
            return;
        end
        n = 0;
        while (busy && n < 20) begin
            wait_cycle();
            n++;
        end
        if (busy) begin
            checkOutput("busy_fall_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput(tag, {20'd0, bcd}, {20'd0, exp_bcd(v)});
        shown = v;
        wait_cycle();
    endtask

    initial begin
        int v;
        seg_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        rst_n  = 1'b0;
        sum_in = 8'd0;

        // Reset values
        repeat (3) wait_cycle();
        checkOutput("rst_seg", {24'd0, seg}, 32'hFF);
        checkOutput("rst_sel", {29'd0, sel}, 32'd7);
        checkOutput("rst_bcd", {20'd0, bcd}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Release: zero is shown with no conversion
        rst_n = 1'b1;
        wait_cycle();
        checkOutput("first_sel", {29'd0, sel}, 32'h6);
        checkOutput("first_seg", {24'd0, seg}, 32'hC0);
        check_scan(0, 30);

        // 255: latency, busy width, no partial results
        sum_in = 8'd255;
        wait_cycle();
        checkOutput("lat_busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            wait_cycle();
            checkOutput("lat_busy", {31'd0, busy}, 32'd1);
            checkOutput("lat_no_partial", {20'd0, bcd}, 32'd0);
        end
        wait_cycle();
        checkOutput("lat_busy_e9", {31'd0, busy}, 32'd0);
        checkOutput("lat_bcd_e9", {20'd0, bcd}, 32'h255);
        shown = 255;
        wait_cycle();
        check_scan(255, 15);

        // Exhaustive conversion of every count
        for (int i = 0; i < 256; i++) applyStimulus(i, "exh_bcd");

        // Blanking cases
        applyStimulus(5, "blank5_bcd");
        check_scan(5, 13);
        applyStimulus(105, "blank105_bcd");
        check_scan(105, 13);

        // Mid-conversion change: 17 then 200 sampled at E3
        sum_in = 8'd17;
        wait_cycle();
        checkOutput("mid_busy_e0", {31'd0, busy}, 32'd1);
        repeat (2) wait_cycle();
        sum_in = 8'd200;
        repeat (6) wait_cycle();
        wait_cycle();
        checkOutput("mid_bcd_e9", {20'd0, bcd}, 32'h017);
        checkOutput("mid_busy_e9", {31'd0, busy}, 32'd0);
        wait_cycle();
        checkOutput("mid_busy_e10", {31'd0, busy}, 32'd1);
        repeat (8) wait_cycle();
        checkOutput("mid_busy_e18", {31'd0, busy}, 32'd1);
        checkOutput("mid_bcd_e18", {20'd0, bcd}, 32'h017);
        wait_cycle();
        checkOutput("mid_bcd_e19", {20'd0, bcd}, 32'h200);
        checkOutput("mid_busy_e19", {31'd0, busy}, 32'd0);
        shown = 200;
        wait_cycle();
        check_scan(200, 13);

        // Reset during conversion aborts and reconverts afterwards
        sum_in = 8'd255;
        repeat (4) wait_cycle();
        rst_n = 1'b0;
        wait_cycle();
        checkOutput("abort_bcd", {20'd0, bcd}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_seg", {24'd0, seg}, 32'hFF);
        checkOutput("abort_sel", {29'd0, sel}, 32'd7);
        wait_cycle();
        rst_n = 1'b1;
        shown = 0;
        applyStimulus(255, "abort_reconv_bcd");
        check_scan(255, 13);

        // Randomized counts with scan checks
        for (int r = 0; r < 40; r++) begin
            v = int'($urandom_range(0, 255));
            applyStimulus(v, "rand_bcd");
            check_scan(v, 13);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
